// File: rtl/clk_div_pkg.sv
`default_nettype none
// ---- clk_div_pkg : state type and divisor check for the divider controller (rev 1.0) ----
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int MIN_DIV = 2;

  function automatic logic div_ok(input logic [31:0] div);
    return (div[0] == 1'b0) && (div >= 32'(MIN_DIV));
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ---- clk_div_core : half-period counter and output toggle for an even divider (rev 1.0) ----
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_fall,
  output logic             o_rise
);

  logic [CNT_W-2:0] cnt;
  logic [CNT_W-1:0] half_m1;
  logic             at_end;

  assign half_m1 = (i_div >> 1) - CNT_W'(1);
  assign at_end  = ({1'b0, cnt} == half_m1);
  assign o_fall  = i_run && o_clk && at_end;
  assign o_rise  = i_run && !i_load && !o_clk && at_end;

  // A load always lands while the output is low or falling, so it restarts the low phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (!i_run || i_load) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (at_end) begin
      cnt   <= '0;
      o_clk <= ~o_clk;
    end else begin
      cnt   <= cnt + (CNT_W-1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_cfg_ctrl.sv
`default_nettype none
// ---- clk_div_cfg_ctrl : glitch-free run/stop and divisor retune for the UART clock (rev 1.0) ----
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_clk,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_cur_div,
  output logic             o_busy
);

  if ((DEFAULT_DIV < MIN_DIV) || ((DEFAULT_DIV % 2) != 0)) begin : g_bad_default_div
    $error("DEFAULT_DIV must be even and at least 2");
  end

  state_t           state, next_state;
  logic [CNT_W-1:0] cur_div, pend_div;
  logic             pend_valid;
  logic             accept, cfg_good;
  logic             core_run, core_load, core_fall, core_rise;
  logic             take_now, store_pend, apply_pend;

  assign o_cfg_ready = (state == IDLE) || (state == RUN);
  assign o_busy      = (state != IDLE);
  assign o_cur_div   = cur_div;
  assign accept      = i_cfg_valid && o_cfg_ready;
  assign cfg_good    = div_ok(32'(i_cfg_div));

  // Outside RUN the counter only advances while high, so a low output can never rise again.
  assign core_run = (state == RUN) || (((state == DRAIN) || (state == STOP)) && o_clk);

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (core_run),
    .i_load (core_load),
    .i_div  (cur_div),
    .o_clk  (o_clk),
    .o_fall (core_fall),
    .o_rise (core_rise)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    take_now   = 1'b0;
    store_pend = 1'b0;
    apply_pend = 1'b0;
    case (state)
      IDLE: begin
        take_now = accept && cfg_good;
        if (i_en) next_state = RUN;
      end
      RUN: begin
        store_pend = accept && cfg_good;
        if (!i_en)          next_state = STOP;
        else if (store_pend) next_state = DRAIN;
      end
      DRAIN: begin
        if (!i_en) begin
          next_state = STOP;
        end else if (!o_clk || core_fall) begin
          core_load  = 1'b1;
          apply_pend = pend_valid;
          next_state = RUN;
        end
      end
      STOP: begin
        if (!o_clk || core_fall) begin
          apply_pend = pend_valid;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur_div    <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      o_cfg_err  <= 1'b0;
      o_tick     <= 1'b0;
    end else begin
      o_cfg_err <= accept && !cfg_good;
      o_tick    <= core_rise;
      if (take_now) begin
        cur_div <= i_cfg_div;
      end else if (apply_pend) begin
        cur_div    <= pend_div;
        pend_valid <= 1'b0;
      end
      if (store_pend) begin
        pend_div   <= i_cfg_div;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_cfg_ctrl.sv
`default_nettype none
// ---- tb_clk_div_cfg_ctrl : directed self-checking bench for clk_div_cfg_ctrl (rev 1.0) ----
module tb_clk_div_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_div = '0;
  logic        cfg_ready, cfg_err, dclk, tick, busy;
  logic [15:0] cur_div;

  int checks = 0;
  int failures = 0;

  clk_div_cfg_ctrl #(.CNT_W(16), .DEFAULT_DIV(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_cfg_valid (cfg_valid),
    .i_cfg_div   (cfg_div),
    .o_cfg_ready (cfg_ready),
    .o_cfg_err   (cfg_err),
    .o_clk       (dclk),
    .o_tick      (tick),
    .o_cur_div   (cur_div),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en        = 1'b0;
    cfg_valid = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_clk",   32'(dclk),      0);
    chk("rst_tick",  32'(tick),      0);
    chk("rst_err",   32'(cfg_err),   0);
    chk("rst_div",   32'(cur_div),   2);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_ready", 32'(cfg_ready), 1);

    // Default divide-by-2: toggles every cycle, tick every other cycle
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("d2_clk",  32'(dclk), k % 2);
      chk("d2_tick", 32'(tick), k % 2);
      chk("d2_busy", 32'(busy), 1);
    end
    en = 1'b0;
    step();
    chk("d2_stop_clk",   32'(dclk),      0);
    chk("d2_stop_ready", 32'(cfg_ready), 0);
    step();
    chk("d2_idle_busy", 32'(busy), 0);
    chk("d2_idle_clk",  32'(dclk), 0);

    // Divisor 10 loaded in IDLE, then run
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 16'd10;
    step();
    cfg_valid = 1'b0;
    chk("d10_div",  32'(cur_div), 10);
    chk("d10_busy", 32'(busy),    0);
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("d10_clk",  32'(dclk), ((k / 5) % 2 == 1) ? 1 : 0);
      chk("d10_tick", 32'(tick), (k % 10 == 5) ? 1 : 0);
    end

    // Start at 8 (simultaneous en+cfg), retune to 4 while output high
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 16'd8;
    en        = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("d8_div", 32'(cur_div), 8);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("d8_clk", 32'(dclk), (k >= 4) ? 1 : 0);
    end
    chk("d8_ready", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_div   = 16'd4;
    step();
    cfg_valid = 1'b0;
    chk("drain_ready6", 32'(cfg_ready), 0);
    chk("drain_div6",   32'(cur_div),   8);
    chk("drain_clk6",   32'(dclk),      1);
    step();
    chk("drain_ready7", 32'(cfg_ready), 0);
    chk("drain_div7",   32'(cur_div),   8);
    chk("drain_clk7",   32'(dclk),      1);
    for (int k = 8; k <= 15; k++) begin
      step();
      chk("d4_clk",  32'(dclk), (((k - 8) / 2) % 2 == 1) ? 1 : 0);
      chk("d4_tick", 32'(tick), (k == 10 || k == 14) ? 1 : 0);
      chk("d4_div",  32'(cur_div), 4);
    end
    chk("d4_ready", 32'(cfg_ready), 1);

    // Invalid divisors 7 and 0 while running at 4
    cfg_valid = 1'b1;
    cfg_div   = 16'd7;
    step();
    cfg_valid = 1'b0;
    chk("bad7_err", 32'(cfg_err), 1);
    chk("bad7_div", 32'(cur_div), 4);
    chk("bad7_clk", 32'(dclk),    0);
    step();
    chk("bad7_err_clr", 32'(cfg_err), 0);
    chk("bad7_clk2",    32'(dclk),    0);
    cfg_valid = 1'b1;
    cfg_div   = 16'd0;
    step();
    cfg_valid = 1'b0;
    chk("bad0_err",   32'(cfg_err),   1);
    chk("bad0_div",   32'(cur_div),   4);
    chk("bad0_clk",   32'(dclk),      1);
    chk("bad0_ready", 32'(cfg_ready), 1);
    step();
    chk("bad0_err_clr", 32'(cfg_err), 0);
    chk("bad0_clk2",    32'(dclk),    1);

    // Clean stop at 6 while high; en re-asserted during STOP
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 16'd6;
    en        = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    chk("d6_rise", 32'(dclk), 1);
    en = 1'b0;
    step();
    chk("stop_clk4",   32'(dclk),      1);
    chk("stop_busy4",  32'(busy),      1);
    chk("stop_ready4", 32'(cfg_ready), 0);
    en = 1'b1;
    step();
    chk("stop_clk5", 32'(dclk), 1);
    step();
    chk("stop_idle_clk",  32'(dclk), 0);
    chk("stop_idle_busy", 32'(busy), 0);
    step();
    chk("restart_busy", 32'(busy), 1);
    chk("restart_clk",  32'(dclk), 0);
    step();
    chk("restart_clk8", 32'(dclk), 0);
    step();
    chk("restart_clk9", 32'(dclk), 0);
    step();
    chk("restart_clk10",  32'(dclk), 1);
    chk("restart_tick10", 32'(tick), 1);

    // Async reset in the middle of DRAIN with 12 pending
    cfg_valid = 1'b1;
    cfg_div   = 16'd12;
    step();
    cfg_valid = 1'b0;
    chk("d12_ready", 32'(cfg_ready), 0);
    chk("d12_div",   32'(cur_div),   6);
    chk("d12_clk",   32'(dclk),      1);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk",  32'(dclk),    0);
    chk("arst_div",  32'(cur_div), 2);
    chk("arst_busy", 32'(busy),    0);
    #2 rst = 1'b0;
    step();
    chk("post_busy", 32'(busy),    1);
    chk("post_div",  32'(cur_div), 2);
    chk("post_clk",  32'(dclk),    0);
    step();
    chk("post_clk1",  32'(dclk), 1);
    chk("post_tick1", 32'(tick), 1);
    step();
    chk("post_clk2", 32'(dclk),    0);
    chk("post_div2", 32'(cur_div), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
